// File: rtl/hub75_fb_read_sched_pkg.sv
// Shared hub75 parameter set and small row-arithmetic helpers used by the
// framebuffer read scheduler.
package hub75_fb_read_sched_pkg;

  localparam int HUB75_N_ROWS = 32;

  // Row counter advance with wrap at the last row of the bank.
  function automatic int next_row(input int row, input int n_rows);
    return (row == n_rows - 1) ? 0 : row + 1;
  endfunction

endpackage

// File: rtl/hub75_fb_read_sched.sv
// HUB75 framebuffer read scheduler: preloads row N+1 into the back line buffer
// while the scanner shifts row N, then swaps buffers and starts the scanner.
module hub75_fb_read_sched
  import hub75_fb_read_sched_pkg::*;
#(
  parameter int N_ROWS     = HUB75_N_ROWS,
  parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_run,
  input  logic                  scan_rdy,
  output logic                  scan_go,
  output logic [LOG_N_ROWS-1:0] scan_row,
  output logic [LOG_N_ROWS-1:0] rd_row_addr,
  output logic                  rd_row_load,
  input  logic                  rd_row_rdy,
  output logic                  rd_row_swap,
  input  logic                  frame_swap_req,
  output logic                  frame_swap,
  output logic                  frame_swap_pend
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_LOAD_WAIT = 3'd2;
  localparam logic [2:0] ST_WAIT_SCAN = 3'd3;
  localparam logic [2:0] ST_SWAP_GO   = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    LOAD      = ST_LOAD,
    LOAD_WAIT = ST_LOAD_WAIT,
    WAIT_SCAN = ST_WAIT_SCAN,
    SWAP_GO   = ST_SWAP_GO
  } state_t;

  state_t                  state_r;
  logic [LOG_N_ROWS-1:0]   load_row_r;
  logic [LOG_N_ROWS-1:0]   scan_row_r;
  logic                    scan_go_r;
  logic                    rd_row_load_r;
  logic                    rd_row_swap_r;
  logic                    frame_swap_r;
  logic                    pend_r;
  logic                    last_row_s;
  logic                    serve_s;

  // A request sampled on the edge that launches the last row's swap/go pulses
  // is served by that same boundary pulse, so it never waits a whole frame.
  assign last_row_s = (load_row_r == LOG_N_ROWS'(N_ROWS - 1));
  assign serve_s    = (state_r == WAIT_SCAN) && scan_rdy && last_row_s &&
                      (pend_r || frame_swap_req);

  // Scheduler FSM, row counter, pending-swap flag and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      load_row_r    <= '0;
      scan_row_r    <= '0;
      scan_go_r     <= 1'b0;
      rd_row_load_r <= 1'b0;
      rd_row_swap_r <= 1'b0;
      frame_swap_r  <= 1'b0;
      pend_r        <= 1'b0;
    end else begin
      scan_go_r     <= 1'b0;
      rd_row_load_r <= 1'b0;
      rd_row_swap_r <= 1'b0;
      frame_swap_r  <= 1'b0;

      if (serve_s) begin
        pend_r <= 1'b0;
      end else if (frame_swap_req) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end

      case (state_r)
        IDLE: begin
          load_row_r <= '0;
          if (ctrl_run) begin
            state_r <= LOAD;
          end
        end
        LOAD: begin
          if (rd_row_rdy) begin
            rd_row_load_r <= 1'b1;
            state_r       <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          // The load pulse is high exactly on the first LOAD_WAIT cycle, so it
          // doubles as the guard against a not-yet-dropped rd_row_rdy.
          if (!rd_row_load_r && rd_row_rdy) begin
            state_r <= WAIT_SCAN;
          end
        end
        WAIT_SCAN: begin
          if (scan_rdy) begin
            rd_row_swap_r <= 1'b1;
            scan_go_r     <= 1'b1;
            frame_swap_r  <= serve_s;
            scan_row_r    <= load_row_r;
            load_row_r    <= LOG_N_ROWS'(next_row(int'(load_row_r), N_ROWS));
            state_r       <= SWAP_GO;
          end
        end
        SWAP_GO: begin
          state_r <= ctrl_run ? LOAD : IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign scan_go         = scan_go_r;
  assign scan_row        = scan_row_r;
  assign rd_row_addr     = load_row_r;
  assign rd_row_load     = rd_row_load_r;
  assign rd_row_swap     = rd_row_swap_r;
  assign frame_swap      = frame_swap_r;
  assign frame_swap_pend = pend_r;

endmodule
